// File: rtl/fft_sink_pkg.sv
// Shared constants, state encoding and magnitude helper for the FFT result sink.
package fft_sink_pkg;

  localparam int NFFT   = 512;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    FILL,
    FLUSH,
    HOLD
  } sink_state_t;

  // |re|+|im| carried one bit wider so the most negative input is represented exactly
  function automatic logic [DATA_W:0] abs_sum(input logic [2*DATA_W-1:0] bin);
    logic [DATA_W:0] re_ext;
    logic [DATA_W:0] im_ext;
    logic [DATA_W:0] re_abs;
    logic [DATA_W:0] im_abs;
    re_ext = {bin[DATA_W-1], bin[DATA_W-1:0]};
    im_ext = {bin[2*DATA_W-1], bin[2*DATA_W-1:DATA_W]};
    re_abs = re_ext[DATA_W] ? -re_ext : re_ext;
    im_abs = im_ext[DATA_W] ? -im_ext : im_ext;
    return re_abs + im_abs;
  endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module fft_frame_ram
  import fft_sink_pkg::*;
#(
  parameter int DEPTH = NFFT,
  parameter int AW    = ADDR_W,
  parameter int WIDTH = 2 * DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; the array itself keeps stale contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_result_sink.sv
// AXI4-Stream sink for FFT output bins: captures one frame, checks framing and
// bin order, tracks the peak-magnitude bin and holds the frame for readback.
module fft_result_sink
  import fft_sink_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*DATA_W-1:0]   s_axis_data_tdata,
  input  logic [15:0]           s_axis_data_tuser,
  input  logic                  s_axis_data_tvalid,
  input  logic                  s_axis_data_tlast,
  output logic                  s_axis_data_tready,
  output logic                  frame_ready,
  output logic [ADDR_W:0]       frame_len,
  input  logic                  frame_release,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data_re,
  output logic [DATA_W-1:0]     rd_data_im,
  output logic                  rd_valid,
  output logic [ADDR_W-1:0]     peak_index,
  output logic [DATA_W:0]       peak_mag,
  output logic                  err_tlast_unexpected,
  output logic                  err_tlast_missing,
  output logic                  err_index
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NFFT - 1);

  sink_state_t         state;
  sink_state_t         state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic                beat;
  logic                fill_beat;
  logic                last_slot;
  logic                release_hold;
  logic                rd_fire;
  logic [DATA_W:0]     beat_mag;
  logic [2*DATA_W-1:0] rd_word;
  logic                unused_tuser_hi;

  // Ready depends only on the registered state, never on tvalid
  assign s_axis_data_tready = (state != HOLD);
  assign frame_ready        = (state == HOLD);
  assign beat               = s_axis_data_tvalid && s_axis_data_tready;
  assign fill_beat          = beat && (state == FILL);
  assign last_slot          = (cnt == LAST_ADDR);
  assign release_hold       = frame_release && (state == HOLD);
  assign rd_fire            = rd_en && (state == HOLD);
  assign beat_mag           = abs_sum(s_axis_data_tdata);
  assign rd_data_re         = rd_word[DATA_W-1:0];
  assign rd_data_im         = rd_word[2*DATA_W-1:DATA_W];
  assign unused_tuser_hi    = ^s_axis_data_tuser[15:ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: begin
        if (fill_beat && s_axis_data_tlast) begin
          state_nxt = HOLD;
        end else if (fill_beat && last_slot) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (beat && s_axis_data_tlast) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (frame_release) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Per-frame bookkeeping; the first stored beat always seeds the peak
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt                  <= '0;
      frame_len            <= '0;
      peak_index           <= '0;
      peak_mag             <= '0;
      err_tlast_unexpected <= 1'b0;
      err_tlast_missing    <= 1'b0;
      err_index            <= 1'b0;
      rd_valid             <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (release_hold) begin
        cnt                  <= '0;
        frame_len            <= '0;
        peak_index           <= '0;
        peak_mag             <= '0;
        err_tlast_unexpected <= 1'b0;
        err_tlast_missing    <= 1'b0;
        err_index            <= 1'b0;
      end else if (fill_beat) begin
        cnt <= cnt + ADDR_W'(1);
        if (s_axis_data_tuser[ADDR_W-1:0] != cnt) begin
          err_index <= 1'b1;
        end
        if ((cnt == '0) || (beat_mag > peak_mag)) begin
          peak_index <= cnt;
          peak_mag   <= beat_mag;
        end
        if (s_axis_data_tlast || last_slot) begin
          frame_len <= {1'b0, cnt} + (ADDR_W + 1)'(1);
        end
        if (s_axis_data_tlast && !last_slot) begin
          err_tlast_unexpected <= 1'b1;
        end
        if (!s_axis_data_tlast && last_slot) begin
          err_tlast_missing <= 1'b1;
        end
      end
    end
  end

  fft_frame_ram #(
    .DEPTH (NFFT),
    .AW    (ADDR_W),
    .WIDTH (2 * DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fill_beat),
    .wr_addr (cnt),
    .wr_data (s_axis_data_tdata),
    .rd_en   (rd_fire),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

endmodule

// File: tb/tb_fft_result_sink.sv
// Randomized scoreboard bench for fft_result_sink: a frame-level reference model
// predicts summaries and readback words; a monitor compares what the DUT presents.
module tb_fft_result_sink;
  import fft_sink_pkg::*;

  typedef struct {
    int     len;
    int     pidx;
    longint pmag;
    bit     eu;
    bit     em;
    bit     ei;
  } frame_exp_t;

  typedef struct {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } rd_exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2*DATA_W-1:0] s_axis_data_tdata;
  logic [15:0]         s_axis_data_tuser;
  logic                s_axis_data_tvalid;
  logic                s_axis_data_tlast;
  logic                s_axis_data_tready;
  logic                frame_ready;
  logic [ADDR_W:0]     frame_len;
  logic                frame_release;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data_re;
  logic [DATA_W-1:0]   rd_data_im;
  logic                rd_valid;
  logic [ADDR_W-1:0]   peak_index;
  logic [DATA_W:0]     peak_mag;
  logic                err_tlast_unexpected;
  logic                err_tlast_missing;
  logic                err_index;

  frame_exp_t          frame_q[$];
  rd_exp_t             rd_q[$];
  logic [2*DATA_W-1:0] model_mem [NFFT];
  logic [DATA_W-1:0]   b_re[$];
  logic [DATA_W-1:0]   b_im[$];
  logic [15:0]         b_user[$];
  bit                  b_last[$];
  int                  checks = 0;
  int                  passes = 0;
  bit                  gaps = 1'b0;
  bit                  prev_ready = 1'b0;

  always #5 clk = ~clk;

  fft_result_sink dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .s_axis_data_tdata    (s_axis_data_tdata),
    .s_axis_data_tuser    (s_axis_data_tuser),
    .s_axis_data_tvalid   (s_axis_data_tvalid),
    .s_axis_data_tlast    (s_axis_data_tlast),
    .s_axis_data_tready   (s_axis_data_tready),
    .frame_ready          (frame_ready),
    .frame_len            (frame_len),
    .frame_release        (frame_release),
    .rd_en                (rd_en),
    .rd_addr              (rd_addr),
    .rd_data_re           (rd_data_re),
    .rd_data_im           (rd_data_im),
    .rd_valid             (rd_valid),
    .peak_index           (peak_index),
    .peak_mag             (peak_mag),
    .err_tlast_unexpected (err_tlast_unexpected),
    .err_tlast_missing    (err_tlast_missing),
    .err_index            (err_index)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic longint absVal(input logic [DATA_W-1:0] v);
    longint s;
    s = longint'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [DATA_W-1:0] rnd(input int lim);
    int v;
    v = int'($urandom_range(2 * lim)) - lim;
    return v;
  endfunction

  task automatic pushBeat(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                          input int user, input bit last);
    b_re.push_back(re);
    b_im.push_back(im);
    b_user.push_back(16'(user));
    b_last.push_back(last);
  endtask

  // Frame recipes: 0 ramp, 1 tied peak, 2 early tlast, 3 overlong, 4 bad index,
  // 5 full-range values, 6 partial frame that gets cut off by reset
  task automatic buildFrame(input int kind);
    b_re.delete(); b_im.delete(); b_user.delete(); b_last.delete();
    case (kind)
      0: for (int k = 0; k < NFFT; k++) pushBeat(k, -k, k, k == NFFT - 1);
      1: for (int k = 0; k < NFFT; k++)
           if (k == 10 || k == 300) pushBeat(1000, 0, k, 1'b0);
           else pushBeat(rnd(400), rnd(400), k, k == NFFT - 1);
      2: for (int k = 0; k < 100; k++) pushBeat(rnd(1 << 20), rnd(1 << 20), k, k == 99);
      3: for (int k = 0; k < NFFT + 8; k++)
           if (k >= NFFT) pushBeat(32'h7fff_ffff, 32'h8000_0000, k, k == NFFT + 7);
           else pushBeat(rnd(1000), rnd(1000), k, 1'b0);
      4: for (int k = 0; k < NFFT; k++) pushBeat(rnd(5000), rnd(5000), (k == 7) ? 0 : k, k == NFFT - 1);
      5: for (int k = 0; k < NFFT; k++)
           if (k == 50 || k == 60) pushBeat(32'h8000_0000, 32'h8000_0000, k, k == NFFT - 1);
           else pushBeat($urandom(), $urandom(), k, k == NFFT - 1);
      default: for (int k = 0; k < 200; k++) pushBeat(rnd(9000), rnd(9000), (k == 3) ? 5 : k, 1'b0);
    endcase
  endtask

  // Frame-level reference: stored span ends at the first tlast or at NFFT beats
  task automatic modelFrame();
    frame_exp_t e;
    int         len;
    longint     m;
    len = -1;
    e.eu = 1'b0; e.em = 1'b0; e.ei = 1'b0;
    for (int i = 0; i < b_re.size() && i < NFFT; i++)
      if (b_last[i]) begin
        len = i + 1;
        break;
      end
    if (len < 0) begin
      len = NFFT;
      e.em = 1'b1;
    end else if (len < NFFT) begin
      e.eu = 1'b1;
    end
    e.len = len; e.pmag = -1; e.pidx = 0;
    for (int i = 0; i < len; i++) begin
      m = absVal(b_re[i]) + absVal(b_im[i]);
      if (b_user[i][ADDR_W-1:0] != ADDR_W'(i)) e.ei = 1'b1;
      if (m > e.pmag) begin
        e.pmag = m;
        e.pidx = i;
      end
      model_mem[i] = {b_im[i], b_re[i]};
    end
    frame_q.push_back(e);
  endtask

  task automatic driveFrame();
    int guard;
    bit rdy;
    for (int i = 0; i < b_re.size(); i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        s_axis_data_tvalid = 1'b0;
        repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
      end
      s_axis_data_tvalid = 1'b1;
      s_axis_data_tdata  = {b_im[i], b_re[i]};
      s_axis_data_tuser  = b_user[i];
      s_axis_data_tlast  = b_last[i];
      guard = 0;
      forever begin
        rdy = s_axis_data_tready;
        @(posedge clk); #1;
        if (rdy) break;
        guard++;
        if (guard > 50) begin
          checkOutput("beat_accept_timeout", 0, 1);
          break;
        end
      end
    end
    s_axis_data_tvalid = 1'b0;
    s_axis_data_tlast  = 1'b0;
  endtask

  task automatic issueReads(input int len, input bit with_release);
    int      addrs[$];
    rd_exp_t r;
    logic [2*DATA_W-1:0] w;
    addrs = '{5, 7, 0};
    addrs.push_back(len - 1);
    repeat (6) addrs.push_back(int'($urandom_range(NFFT - 1)));
    foreach (addrs[i]) begin
      rd_en         = 1'b1;
      rd_addr       = ADDR_W'(addrs[i]);
      frame_release = with_release && (i == addrs.size() - 1);
      w    = model_mem[addrs[i]];
      r.re = w[DATA_W-1:0];
      r.im = w[2*DATA_W-1:DATA_W];
      rd_q.push_back(r);
      @(posedge clk); #1;
      if (i == 0) checkOutput("rd_valid_latency", rd_valid, 1);
      if (frame_release) begin
        checkOutput("release_frame_ready", frame_ready, 0);
        checkOutput("release_tready", s_axis_data_tready, 1);
      end
    end
    rd_en = 1'b0;
    frame_release = 1'b0;
    @(posedge clk); #1;
    checkOutput("rd_valid_drop", rd_valid, 0);
  endtask

  task automatic applyStimulus(input int kind, input bit combined_release);
    int guard;
    buildFrame(kind);
    modelFrame();
    driveFrame();
    checkOutput("frame_ready_latency", frame_ready, 1);
    checkOutput("tready_in_hold", s_axis_data_tready, 0);
    guard = 0;
    while (!frame_ready && guard < 10) begin @(posedge clk); #1; guard++; end
    if (!frame_ready) checkOutput("frame_ready_timeout", 0, 1);
    issueReads(frame_q.size() > 0 ? frame_q[frame_q.size() - 1].len : NFFT, combined_release);
    if (frame_ready) begin
      frame_release = 1'b1;
      @(posedge clk); #1;
      frame_release = 1'b0;
      checkOutput("release_frame_ready", frame_ready, 0);
      checkOutput("release_tready", s_axis_data_tready, 1);
    end
    checkOutput("cleared_frame_len", frame_len, 0);
    checkOutput("cleared_peak_mag", peak_mag, 0);
    checkOutput("cleared_errs", {err_tlast_unexpected, err_tlast_missing, err_index}, 0);
    rd_en = 1'b1;
    rd_addr = '0;
    @(posedge clk); #1;
    rd_en = 1'b0;
    checkOutput("rd_outside_hold", rd_valid, 0);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_tready", s_axis_data_tready, 1);
    checkOutput("rst_frame_ready", frame_ready, 0);
    checkOutput("rst_frame_len", frame_len, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rd_data", {rd_data_im, rd_data_re}, 0);
    checkOutput("rst_peak_index", peak_index, 0);
    checkOutput("rst_peak_mag", peak_mag, 0);
    checkOutput("rst_errs", {err_tlast_unexpected, err_tlast_missing, err_index}, 0);
  endtask

  // Monitor: frame summaries on each frame_ready rise, read words on rd_valid
  initial begin : monitor
    frame_exp_t e;
    rd_exp_t    r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ready = 1'b0;
        continue;
      end
      if (frame_ready && !prev_ready) begin
        if (frame_q.size() == 0) checkOutput("unexpected_frame", 1, 0);
        else begin
          e = frame_q.pop_front();
          checkOutput("frame_len", frame_len, e.len);
          checkOutput("peak_index", peak_index, e.pidx);
          checkOutput("peak_mag", peak_mag, e.pmag);
          checkOutput("err_tlast_unexpected", err_tlast_unexpected, e.eu);
          checkOutput("err_tlast_missing", err_tlast_missing, e.em);
          checkOutput("err_index", err_index, e.ei);
        end
      end
      prev_ready = frame_ready;
      if (rd_valid) begin
        if (rd_q.size() == 0) checkOutput("unexpected_read", 1, 0);
        else begin
          r = rd_q.pop_front();
          checkOutput("rd_data_re", rd_data_re, r.re);
          checkOutput("rd_data_im", rd_data_im, r.im);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b1;
    s_axis_data_tdata = '0; s_axis_data_tuser = '0;
    s_axis_data_tvalid = 1'b0; s_axis_data_tlast = 1'b0;
    frame_release = 1'b0; rd_en = 1'b0; rd_addr = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    rst_n = 1'b1;
    @(posedge clk); #1;

    gaps = 1'b0; applyStimulus(0, 1'b0);
    gaps = 1'b1; applyStimulus(0, 1'b1);
    applyStimulus(1, 1'b0);
    applyStimulus(2, 1'b1);
    applyStimulus(0, 1'b0);
    applyStimulus(3, 1'b1);
    applyStimulus(4, 1'b0);
    applyStimulus(5, 1'b1);

    buildFrame(6);
    for (int i = 0; i < b_re.size(); i++) model_mem[i] = {b_im[i], b_re[i]};
    driveFrame();
    #2 rst_n = 1'b0;
    #1;
    checkResetValues();
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(4, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("frame_q_drained", frame_q.size(), 0);
    checkOutput("rd_q_drained", rd_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
